// File: rtl/lc3_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : lc3_regfile_sb
// Description : LC-3 style register file with two combinational read ports,
//               one write-back port, a one-bit-per-register busy scoreboard
//               for in-order issue, and registered NZP condition codes.
//               Optional macro REGFILE_BYPASS_EN forwards write-back data
//               (and a cleared busy flag) to a same-cycle read of the
//               register being written.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dr,
    output logic              issue_ready,
    output logic              cc_n,
    output logic              cc_z,
    output logic              cc_p
);

    localparam int NREGS = 2**ADDR_W;

    // Reset value of {n,z,p}: a cleared machine reads as "zero".
    localparam logic [2:0] CC_RESET = 3'b010;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [2:0]        cc_q;
    logic [2:0]        cc_d;
    logic              issue_accept;

    // Next-state: write-back clears busy first, then an accepted issue sets it
    // so a same-cycle new producer of the same register wins.
    always_comb begin
        regs_d       = regs_q;
        busy_d       = busy_q;
        cc_d         = cc_q;
        issue_accept = issue_en & ~busy_q[issue_dr];
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
            if (wr_data[DATA_W-1]) begin
                cc_d = 3'b100;
            end else if (wr_data == '0) begin
                cc_d = 3'b010;
            end else begin
                cc_d = 3'b001;
            end
        end
        if (issue_accept) begin
            busy_d[issue_dr] = 1'b1;
        end
    end

    // State registers; asynchronous reset wipes data, reservations and codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cc_q   <= CC_RESET;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cc_q   <= cc_d;
        end
    end

    // Combinational read ports with optional write-back forwarding.
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
        rd_busy1 = busy_q[rd_addr1];
        rd_busy2 = busy_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed in reset so reads return the cleared state.
        if (rst_n && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;
        end
        if (rst_n && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
        end
`else
        // Without forwarding, a same-cycle read sees the stored value.
`endif
    end

    assign issue_ready = ~busy_q[issue_dr];
    assign cc_n        = cc_q[2];
    assign cc_z        = cc_q[1];
    assign cc_p        = cc_q[0];

endmodule
`default_nettype wire

// File: tb/tb_lc3_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_regfile_sb
// Description : Self-checking bench for lc3_regfile_sb. Stimulus pushes the
//               expected port values into a queue; a monitor on the falling
//               clock edge pops and compares against the live outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        rd_busy1;
    logic        rd_busy2;
    logic        issue_en;
    logic [2:0]  issue_dr;
    logic        issue_ready;
    logic        cc_n;
    logic        cc_z;
    logic        cc_p;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [37:0] exp;
    } exp_t;

    exp_t sb_q[$];

    lc3_regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .rd_busy1    (rd_busy1),
        .rd_busy2    (rd_busy2),
        .issue_en    (issue_en),
        .issue_dr    (issue_dr),
        .issue_ready (issue_ready),
        .cc_n        (cc_n),
        .cc_z        (cc_z),
        .cc_p        (cc_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expectation: {rd1, rd2, busy1, busy2, ready, nzp}.
    task automatic expect_out(input string nm, input logic [15:0] d1, input logic [15:0] d2,
                              input logic b1, input logic b2, input logic rdy,
                              input logic [2:0] nzp);
        exp_t e;
        e.name = nm;
        e.exp  = {d1, d2, b1, b2, rdy, nzp};
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra1, input logic [2:0] ra2,
                         input logic ie, input logic [2:0] idr);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = ra1;
        rd_addr2 = ra2;
        issue_en = ie;
        issue_dr = idr;
    endtask

    // Monitor: compare every queued expectation against the outputs at negedge.
    initial begin
        exp_t        e;
        logic [37:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {rd_data1, rd_data2, rd_busy1, rd_busy2, issue_ready, cc_n, cc_z, cc_p};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got rd1=%h rd2=%h b1=%b b2=%b rdy=%b nzp=%b, want rd1=%h rd2=%h b1=%b b2=%b rdy=%b nzp=%b",
                             e.name, act[37:22], act[21:6], act[5], act[4], act[3], act[2:0],
                             e.exp[37:22], e.exp[21:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd7, 1'b0, 3'd0);
        #1;
        expect_out("reset_state", 16'h0, 16'h0, 0, 0, 1, 3'b010);
        cyc();
        cyc();
        rst_n = 1'b1;
        expect_out("post_reset", 16'h0, 16'h0, 0, 0, 1, 3'b010);

        // Condition-code sequence on R2
        cyc();
        drive(1'b1, 3'd2, 16'h8001, 3'd2, 3'd7, 1'b0, 3'd0);
        expect_out("wr_r2_8001_same", BYP ? 16'h8001 : 16'h0, 16'h0, 0, 0, 1, 3'b010);
        cyc();
        drive(1'b0, 3'd2, 16'h0, 3'd2, 3'd7, 1'b0, 3'd0);
        expect_out("r2_8001_neg", 16'h8001, 16'h0, 0, 0, 1, 3'b100);
        cyc();
        drive(1'b1, 3'd2, 16'h0000, 3'd2, 3'd7, 1'b0, 3'd0);
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd7, 1'b0, 3'd0);
        expect_out("r2_0000_zero", 16'h0, 16'h0, 0, 0, 1, 3'b010);
        cyc();
        drive(1'b1, 3'd2, 16'h0005, 3'd2, 3'd7, 1'b0, 3'd0);
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd7, 1'b0, 3'd0);
        expect_out("r2_0005_pos", 16'h0005, 16'h0, 0, 0, 1, 3'b001);
        cyc();
        expect_out("cc_hold", 16'h0005, 16'h0, 0, 0, 1, 3'b001);

        // Issue R4, re-issue while busy, then write-back clears it
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd4, 3'd7, 1'b1, 3'd4);
        expect_out("issue_r4_ready", 16'h0, 16'h0, 0, 0, 1, 3'b001);
        cyc();
        expect_out("reissue_r4_busy", 16'h0, 16'h0, 1, 0, 0, 3'b001);
        cyc();
        drive(1'b1, 3'd4, 16'h1234, 3'd4, 3'd7, 1'b0, 3'd4);
        expect_out("wr_r4_same", BYP ? 16'h1234 : 16'h0, 16'h0, BYP ? 1'b0 : 1'b1, 0, 0, 3'b001);
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd4, 3'd7, 1'b0, 3'd4);
        expect_out("r4_written", 16'h1234, 16'h0, 0, 0, 1, 3'b001);

        // Same-cycle issue and write of R5: new producer wins
        cyc();
        drive(1'b1, 3'd5, 16'h00AA, 3'd5, 3'd7, 1'b1, 3'd5);
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd7, 1'b0, 3'd5);
        expect_out("r5_issue_and_wr", 16'h00AA, 16'h0, 1, 0, 0, 3'b001);

        // Same-cycle read of a register being written
        cyc();
        drive(1'b1, 3'd1, 16'h0042, 3'd1, 3'd5, 1'b0, 3'd0);
        cyc();
        drive(1'b1, 3'd1, 16'hBEEF, 3'd1, 3'd5, 1'b0, 3'd0);
        expect_out("bypass_beef", BYP ? 16'hBEEF : 16'h0042, 16'h00AA, 0, 1, 1, 3'b001);
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd5, 1'b0, 3'd0);
        expect_out("r1_beef", 16'hBEEF, 16'h00AA, 0, 1, 1, 3'b100);

        // Reserve R6 with data, then asynchronous reset mid-cycle
        cyc();
        drive(1'b1, 3'd6, 16'h0777, 3'd6, 3'd5, 1'b1, 3'd6);
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd5, 1'b0, 3'd6);
        expect_out("r6_reserved", 16'h0777, 16'h00AA, 1, 1, 0, 3'b001);
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 16'h0, 16'h0, 0, 0, 1, 3'b010);
        // Writes and issues presented during reset must be ignored
        cyc();
        drive(1'b1, 3'd6, 16'hFFFF, 3'd6, 3'd5, 1'b1, 3'd6);
        cyc();
        expect_out("ignored_in_reset", 16'h0, 16'h0, 0, 0, 1, 3'b010);
        cyc();
        drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd5, 1'b0, 3'd6);
        rst_n = 1'b1;
        expect_out("after_reset_rel", 16'h0, 16'h0, 0, 0, 1, 3'b010);
        cyc();

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            cyc();
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc3_regfile_sb.md
LC3_REGFILE_SB -- requirements
Module: lc3_regfile_sb

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the register address width; register count NREGS = 2**ADDR_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 wr_en  input  1  SHALL be the write-back strobe.
REQ-006 wr_addr  input  ADDR_W  SHALL be the write-back destination register.
REQ-007 wr_data  input  DATA_W  SHALL be the write-back value.
REQ-008 rd_addr1, rd_addr2  input  ADDR_W each  SHALL be the two read-port source registers.
REQ-009 rd_data1, rd_data2  output  DATA_W each  SHALL be the combinational read data.
REQ-010 rd_busy1, rd_busy2  output  1 each  SHALL flag a pending write to the register on the matching read port.
REQ-011 issue_en  input  1  SHALL request reservation of a destination register.
REQ-012 issue_dr  input  ADDR_W  SHALL be the destination register to reserve.
REQ-013 issue_ready  output  1  SHALL be high when issue_dr is not busy.
REQ-014 cc_n, cc_z, cc_p  output  1 each  SHALL be the registered LC-3 condition codes.

Function
REQ-015 Register array SHALL be NREGS x DATA_W; a write SHALL land on the rising edge when wr_en=1.
REQ-016 rd_dataX SHALL equal reg[rd_addrX] with zero-cycle latency, subject to REQ-027.
REQ-017 Busy scoreboard SHALL be one bit per register; rd_busyX = busy[rd_addrX] and issue_ready = ~busy[issue_dr], both combinational.
REQ-018 An issue is accepted when issue_en=1 and issue_ready=1; acceptance SHALL set busy[issue_dr] at the next edge.
REQ-019 When issue_en=1 and issue_ready=0, the issue SHALL be ignored with no state change.
REQ-020 A write with wr_en=1 SHALL clear busy[wr_addr] at the same edge.
REQ-021 If an accepted issue and a write target the same register in the same cycle, busy SHALL end set (the new producer wins) and the data SHALL still be written.
REQ-022 A write to a non-busy register SHALL be legal and SHALL leave busy clear.
REQ-023 Each write SHALL update the condition codes at the same edge from wr_data: MSB=1 gives NZP=100; all-zero gives 010; otherwise 001. Exactly one code SHALL be high at all times.
REQ-024 Cycles with wr_en=0 SHALL hold the condition codes.
REQ-025 Sign and zero tests SHALL use the full DATA_W width.

Reset
REQ-026 On rst_n=0, immediately and independent of clk: all registers SHALL clear to 0, all busy bits SHALL clear, and {cc_n,cc_z,cc_p} SHALL be 010. With rd_addrX unchanged, rd_dataX SHALL read 0, rd_busyX 0, and issue_ready 1. While rst_n=0, writes and issues SHALL be ignored; a reset asserted mid-operation SHALL discard all pending reservations.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read whose rd_addrX equals wr_addr while wr_en=1 SHALL return wr_data in that same cycle, and its rd_busyX SHALL read 0.
REQ-028 Without REGFILE_BYPASS_EN, that read SHALL return the stored (old) value and the unmodified busy bit until the edge.

Verification
REQ-029 Reset, then rd_addr1=3 and rd_addr2=7 -> rd_data 0000/0000, busy 0/0, NZP=010, issue_ready=1.
REQ-030 Write R2=8001, then rd_addr1=2 -> rd_data1=8001, NZP=100; write R2=0000 -> NZP=010; write R2=0005 -> NZP=001.
REQ-031 Issue R4, then re-issue R4 next cycle -> rd_busy(R4)=1, issue_ready=0, second issue ignored; write R4=1234 -> busy clears, rd_data=1234.
REQ-032 Same cycle: issue R5 plus write R5=00AA (R5 not busy) -> after the edge R5=00AA, busy[R5]=1.
REQ-033 wr_en=1, wr_addr=1, wr_data=BEEF, rd_addr1=1 in the same cycle -> rd_data1=BEEF with REGFILE_BYPASS_EN defined, old value without it.
REQ-034 Issue R6, then pulse rst_n low mid-cycle -> busy[R6]=0 and R6=0000 immediately, without waiting for a clk edge.
